// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Operand forwarding and hazard unit for the decode/issue stage.
//   Each read port picks its operand from the highest-priority matching
//   forwarding port (index 0 = youngest stage, last = writeback), falling
//   back to register-file data. A per-register pending-writer counter
//   catches long-latency producers that are not yet visible in any stage.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               squash all in-flight writers (counters cleared)
//   issue_valid/rd/wen  instruction attempting issue and its destination
//   wb_valid/wb_rd      writer retiring this cycle
//   fwd_valid/ready     per forwarding port: holds a writer / data is final
//   fwd_dst/fwd_data    per forwarding port destination and result
//   rs/rf_data          per read port source index and register-file data
//   src_data            resolved operand per read port
//   stall               hold decode this cycle
//   busy_vec            bit r set while register r has writers in flight
//   stall_cycles        saturating count of stalled cycles
//   err_underflow       sticky: writeback seen for a register with none pending
module fwd_scoreboard #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned RW   = $clog2(NREG),
    parameter int unsigned NFWD = 4,
    parameter int unsigned NRD  = 2,
    parameter int unsigned CNTW = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [RW-1:0]        issue_rd,
    input  logic                 issue_wen,
    input  logic                 wb_valid,
    input  logic [RW-1:0]        wb_rd,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*RW-1:0]   fwd_dst,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NRD*RW-1:0]    rs,
    input  logic [NRD*XLEN-1:0]  rf_data,
    output logic [NRD*XLEN-1:0]  src_data,
    output logic                 stall,
    output logic [NREG-1:0]      busy_vec,
    output logic [31:0]          stall_cycles,
    output logic                 err_underflow
);

    logic [CNTW-1:0] pending_q [NREG];
    logic [CNTW-1:0] pending_d [NREG];
    logic [31:0]     stall_cycles_q, stall_cycles_d;
    logic            err_underflow_q, err_underflow_d;

    logic [NRD-1:0]  port_hazard;
    logic [NRD-1:0]  fwd_hit;
    logic            sat_hazard;
    logic            accepted;
    logic            inc;
    logic            dec;

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_vec[r] = (pending_q[r] != '0);
        end
    end

    // Operand select. Ports are scanned from lowest priority to highest so
    // the last assignment made is the lowest-index match; a not-ready
    // high-priority match therefore masks any older ready one.
    always_comb begin
        src_data    = '0;
        port_hazard = '0;
        fwd_hit     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (rs[k*RW +: RW] != '0) begin
                for (int unsigned p = NFWD; p > 0; p--) begin
                    if (fwd_valid[p-1] && (fwd_dst[(p-1)*RW +: RW] == rs[k*RW +: RW])) begin
                        fwd_hit[k]                = 1'b1;
                        src_data[k*XLEN +: XLEN]  = fwd_data[(p-1)*XLEN +: XLEN];
                        port_hazard[k]            = !fwd_ready[p-1];
                    end
                end
                if (!fwd_hit[k]) begin
                    src_data[k*XLEN +: XLEN] = rf_data[k*XLEN +: XLEN];
                    for (int unsigned r = 1; r < NREG; r++) begin
                        if ((rs[k*RW +: RW] == RW'(r)) && busy_vec[r]) begin
                            port_hazard[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A full counter cannot take another writer, so the issue waits.
    always_comb begin
        sat_hazard = 1'b0;
        if (issue_valid && issue_wen && (issue_rd != '0)) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if ((issue_rd == RW'(r)) && (pending_q[r] == '1)) begin
                    sat_hazard = 1'b1;
                end
            end
        end
    end

    assign stall    = issue_valid && ((|port_hazard) || sat_hazard);
    assign accepted = issue_valid && !stall && !flush;
    assign inc      = accepted && issue_wen && (issue_rd != '0);
    assign dec      = wb_valid && (wb_rd != '0) && !flush;

    always_comb begin
        err_underflow_d = err_underflow_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            pending_d[r] = pending_q[r];
        end
        if (flush) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                pending_d[r] = '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (dec && (wb_rd == RW'(r)) && (pending_q[r] == '0)) begin
                    err_underflow_d = 1'b1;
                end
                if (inc && (issue_rd == RW'(r)) && !(dec && (wb_rd == RW'(r)))) begin
                    pending_d[r] = pending_q[r] + CNTW'(1);
                end else if (dec && (wb_rd == RW'(r)) && !(inc && (issue_rd == RW'(r)))
                             && (pending_q[r] != '0)) begin
                    pending_d[r] = pending_q[r] - CNTW'(1);
                end
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                pending_q[r] <= '0;
            end
            stall_cycles_q  <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                pending_q[r] <= pending_d[r];
            end
            stall_cycles_q  <= stall_cycles_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int RW   = 5;
    localparam int NFWD = 4;
    localparam int NRD  = 2;
    localparam int CNTW = 2;

    logic                 clk;
    logic                 reset_n;
    logic                 flush;
    logic                 issue_valid;
    logic [RW-1:0]        issue_rd;
    logic                 issue_wen;
    logic                 wb_valid;
    logic [RW-1:0]        wb_rd;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD-1:0]      fwd_ready;
    logic [NFWD*RW-1:0]   fwd_dst;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NRD*RW-1:0]    rs;
    logic [NRD*XLEN-1:0]  rf_data;
    logic [NRD*XLEN-1:0]  src_data;
    logic                 stall;
    logic [NREG-1:0]      busy_vec;
    logic [31:0]          stall_cycles;
    logic                 err_underflow;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    fwd_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .RW(RW), .NFWD(NFWD), .NRD(NRD), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .rs(rs), .rf_data(rf_data),
        .src_data(src_data), .stall(stall), .busy_vec(busy_vec),
        .stall_cycles(stall_cycles), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_v(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic got(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        fwd_valid = '0;
        fwd_ready = '1;
        fwd_dst   = '0;
        fwd_data  = '0;
    endtask

    task automatic set_fwd(input int p, input logic v, input logic r,
                           input logic [RW-1:0] d, input logic [63:0] data);
        fwd_valid[p]          = v;
        fwd_ready[p]          = r;
        fwd_dst[p*RW +: RW]   = d;
        fwd_data[p*XLEN +: XLEN] = data;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_wen = 1'b0;
        wb_valid = 1'b0; wb_rd = '0;
        rs = '0; rf_data = '0;
        clr_fwd();
        #2;
        expect_v("reset_busy", 64'd0);
        expect_v("reset_stall_cycles", 64'd0);
        expect_v("reset_err", 64'd0);
        got(64'(busy_vec)); got(64'(stall_cycles)); got(64'(err_underflow));
        #10 reset_n = 1'b1;
        tick();

        // Priority: port 1 beats port 2, port 0/3 not valid
        rs = {5'd3, 5'd5};
        rf_data = {64'h3333, 64'h5555};
        set_fwd(0, 1'b0, 1'b1, 5'd5, 64'hAA);
        set_fwd(1, 1'b1, 1'b1, 5'd5, 64'h11);
        set_fwd(2, 1'b1, 1'b1, 5'd5, 64'h22);
        set_fwd(3, 1'b0, 1'b1, 5'd5, 64'hBB);
        issue_valid = 1'b1; issue_wen = 1'b0;
        expect_v("prio_src0", 64'h11);
        expect_v("prio_src1_rf", 64'h3333);
        expect_v("prio_stall", 64'd0);
        #1;
        got(src_data[63:0]); got(src_data[127:64]); got(64'(stall));
        tick();
        expect_v("prio_stall_cycles", 64'd0);
        got(64'(stall_cycles));

        // Load-use
        clr_fwd();
        set_fwd(0, 1'b1, 1'b0, 5'd7, 64'h55);
        rs = {5'd7, 5'd0};
        expect_v("lu_stall", 64'd1);
        expect_v("lu_src0_zero", 64'd0);
        #1;
        got(64'(stall)); got(src_data[63:0]);
        tick();
        expect_v("lu_stall_cycles", 64'd1);
        got(64'(stall_cycles));
        set_fwd(0, 1'b1, 1'b1, 5'd7, 64'hABCD);
        expect_v("lu_ready_stall", 64'd0);
        expect_v("lu_ready_src1", 64'hABCD);
        #1;
        got(64'(stall)); got(src_data[127:64]);
        tick();
        expect_v("lu_stall_cycles_hold", 64'd1);
        got(64'(stall_cycles));

        // Long-latency writer on r9
        clr_fwd();
        rs = '0;
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd9;
        expect_v("ll_issue_stall", 64'd0);
        #1;
        got(64'(stall));
        tick();
        issue_valid = 1'b0; issue_wen = 1'b0;
        expect_v("ll_busy9", 64'h200);
        got(64'(busy_vec));
        issue_valid = 1'b1;
        rs = {5'd0, 5'd9};
        rf_data = {64'h0, 64'h999};
        expect_v("ll_read_stall", 64'd1);
        #1;
        got(64'(stall));
        tick();
        expect_v("ll_stall_cycles", 64'd2);
        got(64'(stall_cycles));
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9;
        set_fwd(3, 1'b1, 1'b1, 5'd9, 64'h9999);
        expect_v("ll_wb_fwd_src0", 64'h9999);
        expect_v("ll_wb_stall", 64'd0);
        #1;
        got(src_data[63:0]); got(64'(stall));
        tick();
        wb_valid = 1'b0;
        clr_fwd();
        expect_v("ll_busy_clear", 64'd0);
        got(64'(busy_vec));
        issue_valid = 1'b1;
        expect_v("ll_after_stall", 64'd0);
        expect_v("ll_after_src0_rf", 64'h999);
        expect_v("ll_after_stall_cycles", 64'd2);
        #1;
        got(64'(stall)); got(src_data[63:0]); got(64'(stall_cycles));
        tick();

        // Saturation on r3
        rs = '0;
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd3;
        expect_v("sat_first_stall", 64'd0);
        #1;
        got(64'(stall));
        tick(); tick(); tick();
        expect_v("sat_busy3", 64'h8);
        expect_v("sat_stall", 64'd1);
        #1;
        got(64'(busy_vec)); got(64'(stall));
        tick();
        expect_v("sat_stall_cycles", 64'd3);
        expect_v("sat_busy_hold", 64'h8);
        got(64'(stall_cycles)); got(64'(busy_vec));
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick();
        issue_valid = 1'b1;
        expect_v("sat_inc_dec_stall", 64'd0);
        #1;
        got(64'(stall));
        tick();
        issue_valid = 1'b0;
        tick();
        expect_v("sat_count1_busy", 64'h8);
        got(64'(busy_vec));
        tick();
        wb_valid = 1'b0;
        expect_v("sat_count0_busy", 64'd0);
        expect_v("sat_no_underflow", 64'd0);
        got(64'(busy_vec)); got(64'(err_underflow));

        // Flush and underflow
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd1;
        tick();
        issue_rd = 5'd2;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        expect_v("fl_busy_pre", 64'h16);
        got(64'(busy_vec));
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd1;
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        expect_v("fl_busy_post", 64'd0);
        expect_v("fl_err_clear", 64'd0);
        got(64'(busy_vec)); got(64'(err_underflow));
        wb_rd = 5'd6;
        tick();
        wb_valid = 1'b0;
        expect_v("uf_err_set", 64'd1);
        got(64'(err_underflow));
        tick(); tick();
        expect_v("uf_err_sticky", 64'd1);
        got(64'(err_underflow));

        // Reset while stalled on a pending writer
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd8;
        tick();
        issue_wen = 1'b0;
        rs = {5'd0, 5'd8};
        expect_v("rst_pre_stall", 64'd1);
        #1;
        got(64'(stall));
        reset_n = 1'b0;
        expect_v("rst_stall", 64'd0);
        expect_v("rst_busy", 64'd0);
        expect_v("rst_err", 64'd0);
        expect_v("rst_stall_cycles", 64'd0);
        #1;
        got(64'(stall)); got(64'(busy_vec)); got(64'(err_underflow)); got(64'(stall_cycles));
        #2 reset_n = 1'b1;
        issue_valid = 1'b0;
        tick();

        // Register zero
        issue_valid = 1'b1; issue_wen = 1'b0;
        rs = '0;
        rf_data = {64'h1234, 64'h5678};
        clr_fwd();
        set_fwd(0, 1'b1, 1'b0, 5'd0, 64'hDEAD);
        expect_v("r0_src0", 64'd0);
        expect_v("r0_src1", 64'd0);
        expect_v("r0_stall", 64'd0);
        #1;
        got(src_data[63:0]); got(src_data[127:64]); got(64'(stall));
        issue_wen = 1'b1; issue_rd = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0;
        tick();
        issue_valid = 1'b0; wb_valid = 1'b0;
        expect_v("r0_busy", 64'd0);
        expect_v("r0_err", 64'd0);
        expect_v("r0_stall_cycles", 64'd0);
        got(64'(busy_vec)); got(64'(err_underflow)); got(64'(stall_cycles));

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard unit for the decode/issue stage.
- Selects each source operand from NFWD priority-ordered pipeline forwarding ports, falling back to register-file data.
- Keeps a per-register pending-writer scoreboard, so long-latency producers (mul/div, outstanding loads) not visible in any forwarding stage cause a stall instead of a stale read.
- Generates the stall signal, a sticky underflow error and a stall-cycle performance counter.

Parameters:
- XLEN, 64, operand width
- NREG, 32, architectural registers; register 0 hard-wired zero
- RW, 5, register index width, $clog2(NREG)
- NFWD, 4, forwarding ports; index 0 highest priority (youngest stage); last port is writeback
- NRD, 2, operand read ports
- CNTW, 2, pending-writer counter width per register

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  squash all in-flight writers
- issue_valid  in  1  decode instruction attempting issue
- issue_rd  in  RW  destination of issuing instruction
- issue_wen  in  1  issuing instruction writes rd
- wb_valid  in  1  a writer retires this cycle
- wb_rd  in  RW  register being written back
- fwd_valid  in  NFWD  forwarding port p holds a register writer
- fwd_ready  in  NFWD  data on port p is final (0 = load or multi-cycle op still pending)
- fwd_dst  in  NFWD*RW  destination per port
- fwd_data  in  NFWD*XLEN  result per port
- rs  in  NRD*RW  source register per read port
- rf_data  in  NRD*XLEN  register-file read data per port
- src_data  out  NRD*XLEN  resolved operand per port
- stall  out  1  hold decode this cycle
- busy_vec  out  NREG  bit r = pending[r] != 0
- stall_cycles  out  32  count of cycles with stall=1
- err_underflow  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all pending counters, stall_cycles and err_underflow go to 0.
  - busy_vec therefore reads 0.
  - src_data and stall are combinational and are not reset.
- Operand select, per port k, combinational:
  - If rs[k]==0: src_data=0, no hazard.
  - Otherwise take the lowest index p with fwd_valid[p] && fwd_dst[p]==rs[k].
    - If fwd_ready[p]=1: src_data=fwd_data[p], no hazard.
    - If fwd_ready[p]=0: hazard, and src_data=fwd_data[p] (don't-care). Lower-priority matches are never used in this case.
  - If no port matches: src_data=rf_data[k]. Hazard when pending[rs[k]]!=0 (writer in flight but not visible in any stage).
- Saturation hazard: issue_valid && issue_wen && issue_rd!=0 && pending[issue_rd]==2^CNTW-1.
- stall = issue_valid && (any port hazard || saturation hazard). With issue_valid=0, stall=0.
- Issue accepted = issue_valid && !stall && !flush.
- Scoreboard update at posedge clk:
  - inc = accepted && issue_wen && issue_rd!=0.
  - dec = wb_valid && wb_rd!=0 && !flush.
  - Same register, inc and dec together: counter unchanged.
  - dec with pending==0: counter stays 0 and err_underflow is set (sticky until reset).
  - inc never wraps; saturation stalls it first.
- flush=1: all counters cleared to 0 at the next edge. Issue and writeback in that cycle are ignored. Writers older than the flush point have drained before flush.
- Writeback timing: a register written back this cycle is still counted, so the writeback stage is a forwarding port and the same-cycle read is satisfied by forwarding. Register-file write-then-read bypass is not required.
- stall_cycles increments on each cycle with stall=1 and saturates at 0xFFFFFFFF. Cleared by reset only.
- busy_vec reflects the registered counters (post-edge state).
- Reset asserted mid-stall: all state clears immediately; stall falls once no fwd_ready=0 hazard remains.

Test Plan:
- Priority: fwd_valid=4'b0110, all dst=5, data p1=0x11, p2=0x22, all ready, rs[0]=5 -> src_data[0]=0x11, stall=0.
- Load-use: fwd_valid[0]=1, dst=7, ready=0, rs[1]=7, issue_valid=1 -> stall=1 and stall_cycles increments. Next cycle ready=1 with data 0xABCD -> stall=0, src_data[1]=0xABCD.
- Long-latency: issue rd=9 (pending[9]=1, busy_vec[9]=1), then read rs=9 with no fwd match -> stall. After wb_valid rd=9 -> pending=0 and the read returns rf_data.
- Saturation (CNTW=2): three accepted issues to rd=3 -> pending=3. A fourth issue to rd=3 -> stall=1 and the count stays 3. Simultaneous issue and writeback on rd=3 at count 2 -> stays 2.
- Flush and underflow: pending on regs 1, 2, 4 plus flush -> busy_vec=0 next cycle. Later wb_valid rd=6 at count 0 -> err_underflow=1, held until reset_n=0.
- Register zero: rs=0 with a matching fwd_dst=0 not ready -> src_data=0, stall=0. Issue rd=0 -> no counter change.
